piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in serial-out stage that sits directly upstream of the 4-bit serial-in parallel-out shift register.
- Accepts parallel words over a valid/ready handshake and serializes each one MSB-first.
- Drives the downstream serial data input and shift-enable (load) pins, one bit per clk.
- A one-entry holding buffer lets the next word be accepted during shifting, so back-to-back words stream without bubbles.

Parameters:
WIDTH, 4, word width in bits; must equal the downstream register width.
GAP, 0, number of idle clk cycles (sen=0) inserted between consecutive words; legal range 0..15.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
din  input  WIDTH  parallel word from the upstream producer.
din_valid  input  1  din holds a valid word.
din_ready  output  1  block can accept a word; equals !hold_full.
sout  output  1  serial bit to the downstream Din; equals sh_reg[WIDTH-1] when sen=1, else 0.
sen  output  1  shift enable to the downstream load pin; high means the downstream register captures sout at this rising edge.
word_done  output  1  one-cycle pulse; the downstream Q holds the complete word in this cycle.
busy  output  1  state!=IDLE or hold_full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Registers cleared: state=IDLE, hold_full=0, sh_reg=0, bit_cnt=0, gap_cnt=0, word_done=0.
  - Outputs: sen=0, sout=0, busy=0, din_ready=1.
  - The upstream producer must not handshake while rst_n is low; any handshake during reset is discarded.
- Accept:
  - Occurs at a rising edge when din_valid && din_ready.
  - din is stored in hold_reg and hold_full is set.
  - din must stay stable while din_valid=1 and din_ready=0.
- State IDLE:
  - sen=0.
  - If hold_full: sh_reg<=hold_reg, hold_full<=0, bit_cnt<=0, go to SHIFT.
- State SHIFT:
  - sen=1; sout=sh_reg[WIDTH-1].
  - Each edge: sh_reg<=sh_reg<<1 (zero fill), bit_cnt<=bit_cnt+1.
  - On the edge where bit_cnt==WIDTH-1 (last bit):
    - word_done<=1.
    - If GAP==0 and hold_full: reload sh_reg from hold_reg, clear hold_full, bit_cnt<=0, stay in SHIFT (continuous sen).
    - Else if GAP>0: gap_cnt<=0, go to GAP.
    - Else: go to IDLE.
- State GAP:
  - sen=0; gap_cnt increments each edge.
  - When gap_cnt==GAP-1: if hold_full, reload and go to SHIFT; else go to IDLE.
- word_done:
  - Registered; high exactly one cycle after the last sen cycle.
  - Never asserted for a partial word.
- Latency: a word accepted at edge E0 gives sen=1 during the WIDTH cycles following edge E1; word_done is high in the cycle following edge E1+WIDTH.
- Simultaneous events:
  - A reload and a new accept cannot share an edge, because din_ready=!hold_full is sampled before the reload. The new word is accepted one cycle later.
  - With GAP=0, one word is accepted every WIDTH cycles, which sustains full throughput.
- Reset mid-operation:
  - sen drops immediately; the partially shifted word and the buffered word are lost; no word_done.
  - The downstream register retains the partial contents; the receiving logic must ignore them.
- bit_cnt width: clog2(WIDTH). gap_cnt width: 4.

Decomposition:
- Shared package piso_pkg holds:
  - state enum {IDLE, SHIFT, GAP};
  - DEFAULT_WIDTH=4;
  - MAX_GAP=15.
- One natural sub-module: piso_hold_buf, a one-entry valid/ready holding register providing hold_reg, hold_full, a pop input, and din_ready.
- FSM, shifter and counters stay in piso_serializer.

Test Plan (WIDTH=4, downstream 4-bit SIPO model connected; sen drives its load pin, sout drives its Din pin):
1. Hold rst_n=0 for 3 cycles -> sen=0, sout=0, word_done=0, busy=0, din_ready=1. Release rst_n -> all outputs unchanged with no input activity.
2. Single word din=4'b1011 accepted at E0 -> sen=1 for exactly 4 cycles starting after E1; sout sequence 1,0,1,1; word_done pulses once; SIPO Q=4'b1011 in that cycle; busy returns to 0.
3. GAP=0, words 4'hA then 4'h5 presented back-to-back -> 8 consecutive sen cycles with no bubble; word_done pulses 4 cycles apart; Q=4'hA at the first pulse and 4'h5 at the second.
4. GAP=2, words 4'h3 and 4'hC -> sen low for exactly 2 cycles between the words; both words are reconstructed correctly in Q.
5. Backpressure: din_valid held high with 4'h1, 4'h2, 4'h4 -> din_ready=0 while hold is full; all three words emerge in order with no loss or duplication.
6. Reset mid-shift: assert rst_n=0 after 2 bits of 4'hF -> sen=0 asynchronously, no word_done. After release, word 4'h9 serializes as 1,0,0,1 and Q=4'h9 at word_done.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and limits for the parallel-in serial-out stage feeding the
// downstream shift register.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_GAP       = 15;

endpackage : piso_pkg

// File: rtl/piso_hold_buf.sv
// One-entry valid/ready holding register; lets the next word be taken while
// the current one is still being shifted out.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             pop,
    output logic             din_ready,
    output logic [WIDTH-1:0] hold_reg,
    output logic             hold_full
);

    logic accept;

    // Ready is taken from the registered full flag, so a pop and an accept
    // can never land on the same edge.
    assign din_ready = !hold_full;
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (pop) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= din;
            hold_full <= 1'b1;
        end
    end

endmodule : piso_hold_buf

// File: rtl/piso_serializer.sv
// Serializes parallel words MSB-first into the downstream shift register,
// driving its Din (sout) and load (sen) pins one bit per clock.
//
// state | meaning
// IDLE  | nothing shifting; start as soon as the holding buffer has a word
// SHIFT | sen=1, one bit of sh_reg presented per cycle
// GAP   | sen=0 spacer of GAP cycles between consecutive words
module piso_serializer
#(
    parameter int WIDTH = piso_pkg::DEFAULT_WIDTH,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sen,
    output logic             word_done,
    output logic             busy
);

    import piso_pkg::*;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic             GAP_ZERO = (GAP == 0);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t           state;
    logic [WIDTH-1:0] sh_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic             last_bit;
    logic             gap_end;
    logic             pop;

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .pop       (pop),
        .din_ready (din_ready),
        .hold_reg  (hold_reg),
        .hold_full (hold_full)
    );

    assign last_bit = (bit_cnt == LAST_BIT);
    assign gap_end  = (gap_cnt == GAP_LAST);

    // Every path that reloads sh_reg from the buffer must also empty it.
    assign pop = hold_full &&
                 ((state == IDLE) ||
                  (state == SHIFT && last_bit && GAP_ZERO) ||
                  (state == piso_pkg::GAP && gap_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh_reg    <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        sh_reg  <= hold_reg;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_reg  <= sh_reg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        word_done <= 1'b1;
                        if (GAP_ZERO && hold_full) begin
                            sh_reg  <= hold_reg;
                            bit_cnt <= '0;
                        end else if (!GAP_ZERO) begin
                            gap_cnt <= '0;
                            state   <= piso_pkg::GAP;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                piso_pkg::GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_end) begin
                        if (hold_full) begin
                            sh_reg  <= hold_reg;
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sen  = (state == SHIFT);
    assign sout = sen && sh_reg[WIDTH-1];
    assign busy = (state != IDLE) || hold_full;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed bench: a GAP=0 and a GAP=2 serializer, each feeding a 4-bit SIPO
// model, checked against hand-computed bit streams and timings.
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       din_valid;
    logic       sel;

    logic din_ready_0, sout_0, sen_0, word_done_0, busy_0;
    logic din_ready_2, sout_2, sen_2, word_done_2, busy_2;
    logic [3:0] q_0, q_2;

    int checks;
    int failures;
    int cyc;

    piso_serializer #(.WIDTH(4), .GAP(0)) dut_g0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid && !sel),
        .din_ready (din_ready_0),
        .sout      (sout_0),
        .sen       (sen_0),
        .word_done (word_done_0),
        .busy      (busy_0)
    );

    piso_serializer #(.WIDTH(4), .GAP(2)) dut_g2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid && sel),
        .din_ready (din_ready_2),
        .sout      (sout_2),
        .sen       (sen_2),
        .word_done (word_done_2),
        .busy      (busy_2)
    );

    // Downstream SIPO models; no reset, they keep contents like the real part.
    always @(posedge clk) begin
        if (sen_0) q_0 <= {q_0[2:0], sout_0};
        if (sen_2) q_2 <= {q_2[2:0], sout_2};
    end

    logic ready_m, sout_m, sen_m, wd_m, busy_m;
    logic [3:0] q_m;
    assign ready_m = sel ? din_ready_2 : din_ready_0;
    assign sout_m  = sel ? sout_2      : sout_0;
    assign sen_m   = sel ? sen_2       : sen_0;
    assign wd_m    = sel ? word_done_2 : word_done_0;
    assign busy_m  = sel ? busy_2      : busy_0;
    assign q_m     = sel ? q_2         : q_0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Trace of the selected DUT, sampled on the falling edge.
    int         sen_cyc[$];
    int         wd_cyc[$];
    logic [3:0] wd_q[$];
    logic [31:0] sbits;
    int         stall_cnt;

    always @(negedge clk) begin
        if (sen_m) begin
            sen_cyc.push_back(cyc);
            sbits = {sbits[30:0], sout_m};
        end
        if (wd_m) begin
            wd_cyc.push_back(cyc);
            wd_q.push_back(q_m);
        end
        if (din_valid && !ready_m) stall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_trace();
        sen_cyc.delete();
        wd_cyc.delete();
        wd_q.delete();
        sbits     = '0;
        stall_cnt = 0;
    endtask

    // Sends n words; returns the cycle at which the first din_valid was raised.
    task automatic send(input logic [3:0] w0, input logic [3:0] w1,
                        input logic [3:0] w2, input int n, output int t0);
        logic [3:0] words[3];
        int bound;
        words[0] = w0; words[1] = w1; words[2] = w2;
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            din       = words[i];
            din_valid = 1'b1;
            bound = 0;
            while (!ready_m && bound < 50) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 50) check("ready_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int t0;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0; din = '0; din_valid = 1'b0; sel = 1'b0;
        q_0 = '0; q_2 = '0;
        clear_trace();

        // 1. reset
        idle_cycles(3);
        check("rst_sen",   {31'd0, sen_0},       32'd0);
        check("rst_sout",  {31'd0, sout_0},      32'd0);
        check("rst_wd",    {31'd0, word_done_0}, 32'd0);
        check("rst_busy",  {31'd0, busy_0},      32'd0);
        check("rst_ready", {31'd0, din_ready_0}, 32'd1);
        check("rst_ready_g2", {31'd0, din_ready_2}, 32'd1);
        rst_n = 1'b1;
        idle_cycles(3);
        check("post_rst_sen",   {31'd0, sen_0 | sen_2},   32'd0);
        check("post_rst_busy",  {31'd0, busy_0 | busy_2}, 32'd0);
        check("post_rst_ready", {31'd0, din_ready_0},     32'd1);

        // 2. single word 1011
        clear_trace();
        send(4'b1011, 4'h0, 4'h0, 1, t0);
        idle_cycles(12);
        check("single_sen_count", sen_cyc.size(), 32'd4);
        check("single_sen_first", sen_cyc.size() > 0 ? sen_cyc[0] - t0 : -1, 32'd2);
        check("single_sout_bits", sbits, 32'b1011);
        check("single_wd_count",  wd_cyc.size(), 32'd1);
        if (wd_cyc.size() == 1) begin
            check("single_wd_time", wd_cyc[0] - t0, 32'd6);
            check("single_q",       {28'd0, wd_q[0]}, 32'hB);
        end
        check("single_busy_end", {31'd0, busy_m}, 32'd0);

        // 3. GAP=0 back-to-back A,5
        clear_trace();
        send(4'hA, 4'h5, 4'h0, 2, t0);
        idle_cycles(14);
        check("b2b_sen_count", sen_cyc.size(), 32'd8);
        if (sen_cyc.size() == 8)
            check("b2b_no_bubble", sen_cyc[7] - sen_cyc[0], 32'd7);
        check("b2b_sout_bits", sbits, 32'b1010_0101);
        check("b2b_wd_count",  wd_cyc.size(), 32'd2);
        if (wd_cyc.size() == 2) begin
            check("b2b_wd0_time", wd_cyc[0] - t0, 32'd6);
            check("b2b_wd_spacing", wd_cyc[1] - wd_cyc[0], 32'd4);
            check("b2b_q0", {28'd0, wd_q[0]}, 32'hA);
            check("b2b_q1", {28'd0, wd_q[1]}, 32'h5);
        end

        // 4. GAP=2 with 3,C
        sel = 1'b1;
        clear_trace();
        send(4'h3, 4'hC, 4'h0, 2, t0);
        idle_cycles(16);
        check("gap_sen_count", sen_cyc.size(), 32'd8);
        if (sen_cyc.size() == 8) begin
            check("gap_first_run", sen_cyc[3] - sen_cyc[0], 32'd3);
            check("gap_idle_len",  sen_cyc[4] - sen_cyc[3] - 1, 32'd2);
        end
        check("gap_sout_bits", sbits, 32'b0011_1100);
        check("gap_wd_count",  wd_cyc.size(), 32'd2);
        if (wd_cyc.size() == 2) begin
            check("gap_wd_spacing", wd_cyc[1] - wd_cyc[0], 32'd6);
            check("gap_q0", {28'd0, wd_q[0]}, 32'h3);
            check("gap_q1", {28'd0, wd_q[1]}, 32'hC);
        end
        check("gap_busy_end", {31'd0, busy_m}, 32'd0);

        // 5. backpressure 1,2,4
        sel = 1'b0;
        clear_trace();
        send(4'h1, 4'h2, 4'h4, 3, t0);
        idle_cycles(16);
        check("bp_stalled",    {31'd0, stall_cnt > 0}, 32'd1);
        check("bp_sen_count",  sen_cyc.size(), 32'd12);
        check("bp_sout_bits",  sbits, 32'b0001_0010_0100);
        check("bp_wd_count",   wd_cyc.size(), 32'd3);
        if (wd_cyc.size() == 3) begin
            check("bp_q0", {28'd0, wd_q[0]}, 32'h1);
            check("bp_q1", {28'd0, wd_q[1]}, 32'h2);
            check("bp_q2", {28'd0, wd_q[2]}, 32'h4);
        end

        // 6. reset after two bits of F
        clear_trace();
        @(negedge clk);
        t0 = cyc;
        din = 4'hF; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        idle_cycles(3);
        check("mid_sen_before", {31'd0, sen_0}, 32'd1);
        check("mid_bits_before", sen_cyc.size(), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_sen_async",  {31'd0, sen_0},  32'd0);
        check("mid_sout_async", {31'd0, sout_0}, 32'd0);
        check("mid_busy_async", {31'd0, busy_0}, 32'd0);
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(4);
        check("mid_no_wd", wd_cyc.size(), 32'd0);
        clear_trace();
        send(4'h9, 4'h0, 4'h0, 1, t0);
        idle_cycles(12);
        check("post_mid_sout_bits", sbits, 32'b1001);
        check("post_mid_wd_count",  wd_cyc.size(), 32'd1);
        if (wd_cyc.size() == 1)
            check("post_mid_q", {28'd0, wd_q[0]}, 32'h9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_serializer
